fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, running entirely in the FIFO read clock domain.
- Pops DATA_WIDTH-bit words from a FIFO configured for first-word-fall-through and packs RATIO consecutive words into one OUT_WIDTH-bit beat.
- Presents each packed beat on a valid/ready stream with a byte-lane keep mask.
- Partial beats are emitted on an explicit flush request and, optionally, on an idle timeout.

Parameters:
- DATA_WIDTH, 8: FIFO word width. Must be a multiple of 8.
- RATIO, 4: FIFO words per output beat. Range 2..16.
- OUT_WIDTH, DATA_WIDTH*RATIO: output beat width. Derived; do not override.
- TIMEOUT, 16: idle cycles before an automatic partial flush. Range 1..65535. Used only with the optional feature.

Ports:
- rd_clk  in  1  clock; same clock as the FIFO read side.
- rd_rst  in  1  asynchronous active-high reset.
- fifo_dout  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0 (FWFT).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe to the FIFO.
- flush  in  1  request to emit any partial beat. Single-cycle pulse or level.
- m_data  out  OUT_WIDTH  packed beat.
- m_keep  out  OUT_WIDTH/8  byte-valid mask; LSB corresponds to m_data[7:0].
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high while a partial beat is held (cnt != 0) or m_valid=1.

Behaviour:
- Reset (asynchronous assert, released synchronously to rd_rst deassert): m_valid=0, m_data=0, m_keep=0, fifo_rd_en=0, busy=0, cnt=0, acc=0, flush_pend=0, idle_cnt=0.
- Packing order: the first popped word goes to acc[DATA_WIDTH-1:0]; word k goes to slice k.
- cnt counts words held in acc, from 0 to RATIO-1.
- slot_free = !m_valid || m_ready.
- fifo_rd_en is combinational: !fifo_empty && !flush_pend && (cnt != RATIO-1 || slot_free).
  - Never asserted while fifo_empty=1.
  - Never asserted during reset.
- Pop with cnt < RATIO-1: the word is written into slice cnt and cnt increments.
- Pop with cnt = RATIO-1 (completes a beat):
  - m_data = {fifo_dout, acc[lower slices]}, m_keep = all ones, m_valid=1.
  - cnt=0, all in the same edge.
  - Latency: m_valid rises on the edge that pops the last word.
- Output handshake:
  - m_data and m_keep are held stable while m_valid && !m_ready.
  - m_valid clears on m_ready unless a new beat loads in the same edge.
  - Back-to-back sustained throughput is one FIFO word per cycle, i.e. one beat every RATIO cycles.
- Flush:
  - flush=1 sets flush_pend.
  - While flush_pend=1, no pops occur.
  - When flush_pend=1 and slot_free:
    - If cnt > 0: m_data = acc with unused slices zero, m_keep = (1 << (cnt*DATA_WIDTH/8)) - 1, m_valid=1, cnt=0.
    - If cnt = 0: nothing is emitted.
    - In either case flush_pend clears on that edge.
  - Flush asserted on the same cycle as a completing pop: the pop happens (flush_pend was 0). The flush then executes against the new cnt=0, so no empty beat is produced.
- FSM: IDLE (cnt=0, !flush_pend), FILL (cnt>0, !flush_pend), FLUSH (flush_pend=1).
  - IDLE to FILL on a pop.
  - FILL to IDLE on a completing pop.
  - Any state to FLUSH on flush.
  - FLUSH to IDLE when executed.
- busy = (cnt != 0) || m_valid.
- Reset mid-beat discards acc and any pending output beat.

Optional Feature:
- Macro: FIFO_RD_PACKER_TIMEOUT_EN.
- Defined:
  - An idle_cnt of 16 bits increments each cycle with cnt > 0, no pop, and !flush_pend.
  - idle_cnt clears on any pop, on flush execution, or when cnt=0.
  - When idle_cnt reaches TIMEOUT-1 and increments, flush_pend sets on that edge. Behaviour from there is identical to an external flush.
- Undefined: no idle_cnt is instantiated; partial beats wait indefinitely for more data or an external flush.

Test Plan:
1. RATIO=4, DATA_WIDTH=8, m_ready=1; push 0x11,0x22,0x33,0x44 into the FIFO -> one beat m_data=0x44332211, m_keep=4'hF. m_valid is high for exactly 1 cycle, asserted on the edge that pops 0x44.
2. Push 8 bytes 0x01..0x08 with m_ready=0 -> first beat 0x04030201 held stable. fifo_rd_en drops with cnt=3 once 0x07 is held. Release m_ready -> second beat 0x08070605. No byte is lost or duplicated.
3. Push 0xAA,0xBB, then pulse flush -> m_data=0x0000BBAA, m_keep=4'h3. Next byte 0xCC lands in slice 0.
4. Flush with cnt=0 and m_valid=0 -> no beat. flush_pend clears after 1 cycle and busy stays 0.
5. With FIFO_RD_PACKER_TIMEOUT_EN and TIMEOUT=16: push 0x5A, then starve the FIFO -> partial beat m_data=0x0000005A, m_keep=4'h1, appearing 17 cycles after the pop (16 idle cycles plus the flush-execute edge). Without the macro, no beat appears after 100 cycles.
6. Assert rd_rst asynchronously with cnt=2 and a beat pending -> m_valid, m_keep and busy go to 0 immediately. After release, a fresh 4-byte sequence packs starting at slice 0.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs RATIO FWFT FIFO words into one valid/ready beat.
// Optional idle-timeout flush: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO,
  parameter int TIMEOUT    = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic [OUT_WIDTH-1:0]   m_data,
  output logic [OUT_WIDTH/8-1:0] m_keep,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy
);

  localparam int CW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int KW  = OUT_WIDTH / 8;
  localparam int BPW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [OUT_WIDTH-1:0] acc, acc_n, data_n;
  logic [KW-1:0]        keep_n, part_keep;
  logic                 valid_n;
  logic                 flush_pend;
  logic                 slot_free;
  logic                 pop;
  logic                 fill_done;
  logic                 exec;
  logic                 to_fire;

  assign flush_pend = (state == FLUSH);
  assign slot_free  = !m_valid || m_ready;
  assign pop        = !rd_rst && !fifo_empty && !flush_pend &&
                      ((cnt != LAST) || slot_free);
  assign fifo_rd_en = pop;
  assign fill_done  = pop && (cnt == LAST);
  assign exec       = flush_pend && slot_free;
  assign busy       = (cnt != '0) || m_valid;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  logic [15:0] idle_cnt, idle_n;
  logic        idle_inc;

  assign idle_inc = (cnt != '0) && !pop && !flush_pend;
  assign to_fire  = idle_inc && (idle_cnt == 16'(TIMEOUT - 1));

  // Idle counter: runs only while a partial beat sits without new words.
  always_comb begin
    idle_n = idle_cnt;
    if (pop || exec || (cnt == '0)) begin
      idle_n = '0;
    end else if (idle_inc) begin
      idle_n = idle_cnt + 16'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_n;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Byte mask covering the words currently held in the accumulator.
  always_comb begin
    part_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CW'(k) < cnt) begin
        part_keep[k*BPW +: BPW] = '1;
      end
    end
  end

  // Datapath next state: fill, complete a beat, or emit a flushed partial.
  always_comb begin
    cnt_n   = cnt;
    acc_n   = acc;
    data_n  = m_data;
    keep_n  = m_keep;
    valid_n = m_valid && !m_ready;
    if (fill_done) begin
      data_n  = acc;
      data_n[(RATIO-1)*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      keep_n  = '1;
      valid_n = 1'b1;
      cnt_n   = '0;
      acc_n   = '0;
    end else if (pop) begin
      acc_n[cnt*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      cnt_n = cnt + CW'(1);
    end else if (exec && (cnt != '0)) begin
      data_n  = acc;
      keep_n  = part_keep;
      valid_n = 1'b1;
      cnt_n   = '0;
      acc_n   = '0;
    end
  end

  // Control FSM next state.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (flush || to_fire) begin
          state_n = FLUSH;
        end else if (pop) begin
          state_n = FILL;
        end
      end
      FILL: begin
        if (flush || to_fire) begin
          state_n = FLUSH;
        end else if (fill_done) begin
          state_n = IDLE;
        end
      end
      FLUSH: begin
        if (exec) begin
          state_n = flush ? FLUSH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, accumulator and output beat registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      m_data  <= '0;
      m_keep  <= '0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      acc     <= acc_n;
      m_data  <= data_n;
      m_keep  <= keep_n;
      m_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed + random checks against a queue-based model.
// Build with FIFO_RD_PACKER_TIMEOUT_EN to cover the idle-timeout flush.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;
  localparam int KW = OW / 8;
  localparam int TO = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          flush;
  logic [OW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_valid;
  logic          m_ready;
  logic          busy;

  fifo_rd_packer #(
    .DATA_WIDTH(DW),
    .RATIO(R),
    .TIMEOUT(TO)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .flush(flush),
    .m_data(m_data),
    .m_keep(m_keep),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] held[$];
  bit            pend;
  bit            ov;
  logic [OW-1:0] od;
  logic [KW-1:0] ok;
  int            idle;
  int            vcount;
  logic [KW+OW-1:0] beats[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic push(logic [DW-1:0] b);
    fq.push_back(b);
    fifo_drive();
  endtask

  function automatic logic [OW-1:0] pack();
    logic [OW-1:0] v;
    v = '0;
    foreach (held[i]) v[i*DW +: DW] = held[i];
    return v;
  endfunction

  function automatic logic [KW+OW-1:0] beat(int i);
    if (beats.size() > i) return beats[i];
    return '1;
  endfunction

  task automatic model_clear();
    held.delete();
    pend = 0;
    ov   = 0;
    od   = '0;
    ok   = '0;
    idle = 0;
  endtask

  // One clock: check at negedge+1, step model, let the FIFO react.
  task automatic cycle();
    bit slot, pop, ex, fire, rd_seen;
    #1;
    slot = !ov || m_ready;
    pop  = !fifo_empty && !pend && (held.size() != R - 1 || slot);
    check("rd_en", fifo_rd_en, pop);
    check("valid", m_valid, ov);
    check("busy", busy, (held.size() != 0) || ov);
    if (ov) begin
      check("data", m_data, od);
      check("keep", m_keep, ok);
    end
    if (m_valid) vcount++;
    if (m_valid && m_ready) beats.push_back({m_keep, m_data});
    ex   = pend && slot;
    fire = 0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    if (pop || ex || held.size() == 0) begin
      idle = 0;
    end else if (!pend) begin
      if (idle == TO - 1) fire = 1;
      idle++;
    end
`endif
    if (ov && m_ready) ov = 0;
    if (pop) begin
      held.push_back(fq[0]);
      if (held.size() == R) begin
        od = pack();
        ok = '1;
        ov = 1;
        held.delete();
      end
    end else if (ex && held.size() > 0) begin
      od = pack();
      ok = KW'((1 << (held.size() * DW / 8)) - 1);
      ov = 1;
      held.delete();
    end
    pend = (pend && !ex) || flush || fire;
    rd_seen = fifo_rd_en;
    @(posedge rd_clk);
    #1;
    if (rd_seen && fq.size() > 0) void'(fq.pop_front());
    fifo_drive();
    @(negedge rd_clk);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  initial begin
    int lat;
    rd_rst  = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    push(8'h99);
    #2;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_keep", m_keep, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    @(negedge rd_clk);
    @(negedge rd_clk);
    fq.delete();
    fifo_drive();
    model_clear();
    rd_rst = 1'b0;

    // 1: one full beat, valid for exactly one cycle
    m_ready = 1'b1;
    beats.delete();
    vcount = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run(8);
    check("t1_nbeats", beats.size(), 1);
    check("t1_beat", beat(0), {4'hF, 32'h44332211});
    check("t1_vcycles", vcount, 1);

    // 2: backpressure holds beat, stalls with cnt=3
    m_ready = 1'b0;
    beats.delete();
    for (int i = 1; i <= 8; i++) push(8'(i));
    run(12);
    check("t2_stall", fifo_rd_en, 0);
    check("t2_left", fq.size(), 1);
    check("t2_hold", m_data, 32'h04030201);
    m_ready = 1'b1;
    run(8);
    check("t2_nbeats", beats.size(), 2);
    check("t2_beat0", beat(0), {4'hF, 32'h04030201});
    check("t2_beat1", beat(1), {4'hF, 32'h08070605});

    // 3: partial flush, then refill from slice 0
    beats.delete();
    push(8'hAA); push(8'hBB);
    run(4);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(4);
    push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
    run(8);
    check("t3_nbeats", beats.size(), 2);
    check("t3_part", beat(0), {4'h3, 32'h0000BBAA});
    check("t3_next", beat(1), {4'hF, 32'hFFEEDDCC});

    // 4: flush with nothing held emits nothing
    beats.delete();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push(8'h77);
    #1;
    check("t4_blocked", fifo_rd_en, 0);
    check("t4_busy", busy, 0);
    cycle();
    #1;
    check("t4_resume", fifo_rd_en, 1);
    cycle();
    check("t4_nbeats", beats.size(), 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(4);
    check("t4_drain", beat(0), {4'h1, 32'h00000077});

    // 5: starved partial beat (timeout only when enabled)
    beats.delete();
    push(8'h5A);
    cycle();
    lat = -1;
    for (int j = 1; j <= 100; j++) begin
      cycle();
      if (m_valid && lat < 0) lat = j;
    end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    check("t5_latency", lat, 17);
    check("t5_beat", beat(0), {4'h1, 32'h0000005A});
`else
    check("t5_nobeat", lat, -1);
    check("t5_nbeats", beats.size(), 0);
`endif
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(4);

    // 6: async reset with cnt=2 and a beat pending
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    run(10);
    check("t6_pre_valid", m_valid, 1);
    #3;
    rd_rst = 1'b1;
    #1;
    check("t6_valid", m_valid, 0);
    check("t6_keep", m_keep, 0);
    check("t6_busy", busy, 0);
    fq.delete();
    fifo_drive();
    model_clear();
    @(negedge rd_clk);
    rd_rst = 1'b0;
    m_ready = 1'b1;
    beats.delete();
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    run(8);
    check("t6_fresh", beat(0), {4'hF, 32'hD4C3B2A1});

    // random traffic in phases of varying FIFO fill rate
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        m_ready = ($urandom_range(0, 3) != 0);
        flush   = ($urandom_range(0, 63) == 0);
        if (fq.size() < 16 && $urandom_range(0, 5) < ph) push(8'($urandom));
        cycle();
      end
    end
    flush = 1'b0;
    m_ready = 1'b1;
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
